// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: seeds and steps an external 16-bit LFSR and streams a
// burst of LFSR words over valid/ready. Re-seeds on all-zero lock-up.
// Optional build macro: LFSR_BURST_CTRL_CSUM_EN (XOR checksum of transfers).
module lfsr_burst_ctrl #(
  parameter int unsigned            WIDTH        = 16,
  parameter int unsigned            CNT_W        = 16,
  parameter logic [WIDTH-1:0]       DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic [WIDTH-1:0] lfsr_seed,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [7:0]       lock_cnt,
  output logic [WIDTH-1:0] csum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem;
  logic             xfer;
  logic             burst_req;  // IDLE -> LOAD this cycle
  logic             lock_up;    // all-zero LFSR seen in RUN (abort masks it)

  assign xfer      = out_valid & out_ready;
  assign lfsr_en   = xfer;
  assign out_data  = lfsr_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign lfsr_load = (state == S_LOAD);

  // Next-state and handshake outputs; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    burst_req = 1'b0;
    lock_up   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            burst_req = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        if (lfsr_q == '0) begin
          lock_up   = 1'b1;
          state_nxt = S_LOAD;
        end else begin
          out_valid = 1'b1;
          out_last  = (rem == CNT_W'(1));
          if (out_ready && rem == CNT_W'(1))
            state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      lock_up   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Remaining-word counter and latched seed, both captured on burst start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem       <= '0;
      lfsr_seed <= DEFAULT_SEED;
    end else if (burst_req) begin
      rem       <= burst_len;
      lfsr_seed <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (xfer) begin
      rem       <= rem - CNT_W'(1);
    end
  end

  // Saturating lock-up reseed counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        lock_cnt <= '0;
    else if (lock_up && lock_cnt != '1) lock_cnt <= lock_cnt + 8'd1;
  end

`ifdef LFSR_BURST_CTRL_CSUM_EN
  logic [WIDTH-1:0] csum_q;

  // XOR checksum of transferred words, restarted with each new burst.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        csum_q <= '0;
    else if (burst_req) csum_q <= '0;
    else if (xfer)      csum_q <= csum_q ^ lfsr_q;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Testbench for lfsr_burst_ctrl with a behavioural 16-bit LFSR
// (x^16+x^14+x^13+x^11+1, shift left) standing in for lfsr1.
module tb_lfsr_burst_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] seed;
  logic [15:0] burst_len;
  logic        abort;
  logic        lfsr_load;
  logic        lfsr_en;
  logic [15:0] lfsr_seed;
  logic [15:0] lfsr_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [7:0]  lock_cnt;
  logic [15:0] csum;

  logic [15:0] lfsr_reg;
  logic        force_zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] words[$];
  logic        lasts[$];
  int          en_cnt, load_cnt, done_cnt, valid_cnt;
  logic        prev_stall;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  lfsr_burst_ctrl #(.WIDTH(16), .CNT_W(16), .DEFAULT_SEED(16'h0001)) dut (
    .clk(clk), .resetn(resetn), .start(start), .seed(seed),
    .burst_len(burst_len), .abort(abort), .lfsr_load(lfsr_load),
    .lfsr_en(lfsr_en), .lfsr_seed(lfsr_seed), .lfsr_q(lfsr_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .lock_cnt(lock_cnt),
    .csum(csum)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Behavioural LFSR datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        lfsr_reg <= '0;
    else if (lfsr_load) lfsr_reg <= lfsr_seed;
    else if (lfsr_en)   lfsr_reg <= lfsr_step(lfsr_reg);
  end
  assign lfsr_q = force_zero ? 16'h0000 : lfsr_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: records transfers and pulse counts, checks stall stability.
  always @(negedge clk) begin
    if (resetn) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        words.push_back(out_data);
        lasts.push_back(out_last);
      end
      if (lfsr_en)   en_cnt++;
      if (lfsr_load) load_cnt++;
      if (done)      done_cnt++;
      if (out_valid) valid_cnt++;
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    words.delete();
    lasts.delete();
    en_cnt = 0; load_cnt = 0; done_cnt = 0; valid_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] len);
    seed = s; burst_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    check(tag, busy, 0);
  endtask

  // Compare recorded words against the reference LFSR from seed s.
  task automatic check_words(input string tag, input logic [15:0] s, input int n);
    logic [15:0] w;
    w = s;
    check({tag, "_count"}, words.size(), n);
    for (int i = 0; i < n && i < words.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), words[i], w);
      w = lfsr_step(w);
    end
  endtask

  initial begin
    logic [15:0] w, x;
    resetn = 1'b0; start = 1'b0; seed = '0; burst_len = '0; abort = 1'b0;
    out_ready = 1'b0; force_zero = 1'b0;
    clear_stats();
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_load", lfsr_load, 0);
    check("rst_en", lfsr_en, 0);
    check("rst_lock", lock_cnt, 0);
    check("rst_csum", csum, 0);
    check("rst_seed", lfsr_seed, 16'h0001);
    resetn = 1'b1;
    tick();

    // 1: seed 1, len 4, ready high
    clear_stats();
    out_ready = 1'b1;
    do_start(16'h0001, 16'd4);
    check("t1_load", lfsr_load, 1);
    check("t1_novalid", out_valid, 0);
    tick();
    check("t1_v1", out_valid, 1);
    check("t1_d1", out_data, 16'h0001);
    check("t1_l1", out_last, 0);
    tick(); check("t1_d2", out_data, 16'h0002);
    tick(); check("t1_d3", out_data, 16'h0004);
    tick();
    check("t1_d4", out_data, 16'h0008);
    check("t1_l4", out_last, 1);
    tick();
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 1);
    check("t1_valid_done", out_valid, 0);
    tick();
    check("t1_idle", busy, 0);
    check("t1_done_off", done, 0);
    check_words("t1", 16'h0001, 4);
    check("t1_lasts", {lasts[0], lasts[1], lasts[2], lasts[3]}, 4'b0001);
    check("t1_done_cnt", done_cnt, 1);

    // 2: ready toggles every cycle
    clear_stats();
    out_ready = 1'b0;
    do_start(16'h0001, 16'd3);
    for (int i = 0; i < 40 && busy; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    wait_idle("t2_idle");
    check_words("t2", 16'h0001, 3);
    check("t2_en", en_cnt, 3);
    out_ready = 1'b1;

    // 3: seed 0 falls back to default
    clear_stats();
    do_start(16'h0000, 16'd2);
    check("t3_seed", lfsr_seed, 16'h0001);
    wait_idle("t3_idle");
    check_words("t3", 16'h0001, 2);

    // 4: zero-length burst
    clear_stats();
    do_start(16'h1234, 16'd0);
    check("t4_done", done, 1);
    check("t4_load", lfsr_load, 0);
    check("t4_valid", out_valid, 0);
    tick();
    check("t4_idle", busy, 0);
    check("t4_load_cnt", load_cnt, 0);
    check("t4_valid_cnt", valid_cnt, 0);
    check("t4_seed_kept", lfsr_seed, 16'h0001);

    // 5: lock-up forced after the first word
    clear_stats();
    do_start(16'h0001, 16'd3);
    tick();
    tick();
    force_zero = 1'b1;
    #1;
    check("t5_valid_low", out_valid, 0);
    tick();
    force_zero = 1'b0;
    check("t5_reload", lfsr_load, 1);
    check("t5_lock", lock_cnt, 1);
    wait_idle("t5_idle");
    check("t5_count", words.size(), 3);
    if (words.size() == 3) begin
      check("t5_w0", words[0], 16'h0001);
      check("t5_w1", words[1], 16'h0001);
      check("t5_w2", words[2], 16'h0002);
    end
    check("t5_done_cnt", done_cnt, 1);

    // 6: abort during the 5th transfer, then a fresh burst
    clear_stats();
    do_start(16'hACE1, 16'd10);
    tick();
    repeat (4) tick();
    check("t6_v5", out_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_idle", busy, 0);
    check("t6_valid_off", out_valid, 0);
    tick();
    check_words("t6", 16'hACE1, 5);
    check("t6_no_done", done_cnt, 0);

    clear_stats();
    do_start(16'h1234, 16'd3);
    tick();
    seed = 16'h5555; burst_len = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t6b_idle");
    check_words("t6b", 16'h1234, 3);
    check("t6b_loads", load_cnt, 1);
    w = 16'h1234; x = '0;
    for (int i = 0; i < 3; i++) begin
      x = x ^ w;
      w = lfsr_step(w);
    end
`ifdef LFSR_BURST_CTRL_CSUM_EN
    check("t6b_csum", csum, x);
`else
    check("t6b_csum", csum, 0);
`endif
    check("t6b_lock_kept", lock_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
